// File: rtl/cfg_pkg.sv
// cfg_pkg: opcodes, command field positions and FSM states shared by config_reg_bank.
package cfg_pkg;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_CLEAR = 8'h03;
  localparam int OP_LSB   = 24;
  localparam int ADDR_LSB = 16;
  localparam int DATA_LSB = 0;
`ifdef CFG_READBACK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP_HI = 2'd2, RESP_LO = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1} state_t;
`endif
  function automatic logic [7:0] cmd_op(input logic [31:0] c);
    return c[OP_LSB +: 8];
  endfunction
  function automatic logic [7:0] cmd_addr(input logic [31:0] c);
    return c[ADDR_LSB +: 8];
  endfunction
  function automatic logic [15:0] cmd_data(input logic [31:0] c);
    return c[DATA_LSB +: 16];
  endfunction
endpackage

// File: rtl/cfg_fifo.sv
// cfg_fifo: synchronous command FIFO, head word visible on rd_data while not empty.
module cfg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/config_reg_bank.sv
// config_reg_bank: FIFO-fed command engine over a bank of 16-bit config registers.
// Readback (READ opcode, RESP states, resp_* handshake) exists only with CFG_READBACK_EN.
module config_reg_bank
  import cfg_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   config_en,
  input  logic [31:0]            config_data,
  output logic [NUM_REGS*16-1:0] reg_out,
  output logic [NUM_REGS-1:0]    reg_wr_strobe,
  output logic                   busy,
  output logic                   err,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [7:0]             resp_data
);
  state_t state, state_nxt;
  logic push, pop, full, empty, exec, ovf, bad;
  logic wr_ok, rd_ok, clr, addr_ok;
  logic [31:0] head, cmd;
  logic [7:0] op, addr;
  logic [15:0] data;
  logic [NUM_REGS-1:0] sel, hit;
  assign push = config_en && (!full || pop);
  assign ovf = config_en && full && !pop;
  cfg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .wr_data(config_data), .rd_data(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = empty ? IDLE : EXEC;
`ifdef CFG_READBACK_EN
      EXEC:    state_nxt = rd_ok ? RESP_HI : IDLE;
      RESP_HI: state_nxt = resp_ready ? RESP_LO : RESP_HI;
      RESP_LO: state_nxt = resp_ready ? IDLE : RESP_LO;
`else
      EXEC:    state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end
`ifdef CFG_READBACK_EN
  logic [15:0] rdata, rd_word;
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (sel[k]) rd_word = reg_out[16*k +: 16];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (exec && rd_ok) rdata <= rd_word;
`else
  logic unused_resp_ready;
  assign unused_resp_ready = resp_ready;
`endif
  always_comb begin
    pop = (state == IDLE) && !empty;
    exec = state == EXEC;
    busy = !empty || (state != IDLE);
`ifdef CFG_READBACK_EN
    resp_valid = (state == RESP_HI) || (state == RESP_LO);
    resp_data = (state == RESP_HI) ? rdata[15:8] : (state == RESP_LO) ? rdata[7:0] : 8'h00;
`else
    resp_valid = 1'b0;
    resp_data = 8'h00;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cmd <= '0;
    else if (pop) cmd <= head;
  always_comb begin
    op = cmd_op(cmd);
    addr = cmd_addr(cmd);
    data = cmd_data(cmd);
    addr_ok = 32'(addr) < NUM_REGS;
    wr_ok = (op == OP_WRITE) && addr_ok;
    clr = op == OP_CLEAR;
`ifdef CFG_READBACK_EN
    rd_ok = (op == OP_READ) && addr_ok;
`else
    rd_ok = 1'b0;
`endif
    bad = exec && !(wr_ok || clr || rd_ok);
    for (int k = 0; k < NUM_REGS; k++) begin
      sel[k] = 32'(addr) == k;
      hit[k] = exec && (clr || (wr_ok && sel[k]));
    end
  end
  // overflow and bad-command errors merge into one registered pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      reg_out <= '0;
      reg_wr_strobe <= '0;
      err <= 1'b0;
    end else begin
      err <= ovf || bad;
      reg_wr_strobe <= hit;
      for (int k = 0; k < NUM_REGS; k++)
        if (hit[k]) reg_out[16*k +: 16] <= clr ? 16'h0000 : data;
    end
endmodule

// File: tb/tb_config_reg_bank.sv
// tb_config_reg_bank: directed self-checking bench for config_reg_bank (both CFG_READBACK_EN builds).
module tb_config_reg_bank;
  logic clk = 1'b0;
  logic rst, config_en, resp_ready, busy, err, resp_valid;
  logic [31:0] config_data;
  logic [255:0] reg_out;
  logic [15:0] reg_wr_strobe;
  logic [7:0] resp_data;
  logic [15:0] m [16];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  config_reg_bank #(.NUM_REGS(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .config_en(config_en), .config_data(config_data),
    .reg_out(reg_out), .reg_wr_strobe(reg_wr_strobe), .busy(busy), .err(err),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
  );
  function automatic logic [255:0] pack();
    logic [255:0] p;
    for (int k = 0; k < 16; k++) p[16*k +: 16] = m[k];
    return p;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] w);
    config_en = 1'b1;
    config_data = w;
    tick();
    config_en = 1'b0;
  endtask
  task automatic clear_model();
    for (int k = 0; k < 16; k++) m[k] = 16'h0;
  endtask
`ifdef CFG_READBACK_EN
  logic [31:0] burst [6] = '{32'h02030000, 32'h01041111, 32'h01052222,
                             32'h01043333, 32'h01064444, 32'h01075555};
`else
  logic [31:0] burst [9] = '{32'h01041111, 32'h01052222, 32'h01043333,
                             32'h01060006, 32'h01070007, 32'h01080008,
                             32'h01090009, 32'h010A000A, 32'h010BBEEF};
`endif
  initial begin
    rst = 1'b1;
    config_en = 1'b0;
    config_data = '0;
    resp_ready = 1'b0;
    clear_model();
    tick();
    tick();
    chk("rst_regs", reg_out, pack());
    chk("rst_strobe", reg_wr_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    rst = 1'b0;
    send(32'h0103ABCD);
    chk("wr_busy", busy, 1);
    chk("wr_edge1_regs", reg_out, pack());
    tick();
    chk("wr_edge2_regs", reg_out, pack());
    tick();
    m[3] = 16'hABCD;
    chk("wr_edge3_regs", reg_out, pack());
    chk("wr_strobe", reg_wr_strobe, 16'h0008);
    chk("wr_err", err, 0);
    tick();
    chk("wr_strobe_off", reg_wr_strobe, 0);
    chk("wr_idle", busy, 0);
    chk("wr_err_after", err, 0);
    foreach (burst[i]) begin
      config_en = 1'b1;
      config_data = burst[i];
      tick();
    end
    config_en = 1'b0;
    chk("ovf_err", err, 1);
`ifdef CFG_READBACK_EN
    chk("rd_valid", resp_valid, 1);
    chk("rd_hi", resp_data, 8'hAB);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rd_hi_hold", resp_data, 8'hAB);
      chk("rd_hi_valid_hold", resp_valid, 1);
      chk("ovf_err_single", err, 0);
    end
    resp_ready = 1'b1;
    tick();
    chk("rd_lo", resp_data, 8'hCD);
    chk("rd_lo_valid", resp_valid, 1);
    tick();
    resp_ready = 1'b0;
    chk("rd_done", resp_valid, 0);
    repeat (10) tick();
    m[4] = 16'h3333;
    m[5] = 16'h2222;
    m[6] = 16'h4444;
    chk("burst_regs", reg_out, pack());
`else
    tick();
    chk("ovf_err_single", err, 0);
    repeat (12) tick();
    m[4] = 16'h3333;
    m[5] = 16'h2222;
    for (int k = 6; k <= 10; k++) m[k] = 16'(k);
    chk("burst_regs", reg_out, pack());
    send(32'h02030000);
    tick();
    tick();
    chk("rd_invalid_err", err, 1);
    chk("rd_invalid_valid", resp_valid, 0);
    chk("rd_invalid_strobe", reg_wr_strobe, 0);
    tick();
    chk("rd_invalid_regs", reg_out, pack());
`endif
    chk("burst_idle", busy, 0);
    send(32'h01101234);
    tick();
    tick();
    chk("bad_addr_err", err, 1);
    chk("bad_addr_strobe", reg_wr_strobe, 0);
    tick();
    chk("bad_addr_err_off", err, 0);
    chk("bad_addr_regs", reg_out, pack());
    send(32'h7F030000);
    tick();
    tick();
    chk("bad_op_err", err, 1);
    tick();
    chk("bad_op_regs", reg_out, pack());
    send(32'h03000000);
    tick();
    tick();
    clear_model();
    chk("clr_strobe", reg_wr_strobe, 16'hFFFF);
    chk("clr_regs", reg_out, pack());
    tick();
    chk("clr_strobe_off", reg_wr_strobe, 0);
`ifdef CFG_READBACK_EN
    send(32'h01045A5A);
    repeat (3) tick();
    m[4] = 16'h5A5A;
    chk("pre_rst_regs", reg_out, pack());
    send(32'h02040000);
    config_en = 1'b1;
    config_data = 32'h01011111;
    tick();
    config_data = 32'h01022222;
    tick();
    config_en = 1'b0;
    chk("pre_rst_valid", resp_valid, 1);
    chk("pre_rst_hi", resp_data, 8'h5A);
`else
    send(32'h01011111);
    config_en = 1'b1;
    config_data = 32'h01022222;
    tick();
    config_en = 1'b0;
`endif
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    clear_model();
    chk("async_rst_valid", resp_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_regs", reg_out, pack());
    chk("async_rst_strobe", reg_wr_strobe, 0);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("no_late_writes", reg_out, pack());
    chk("post_rst_idle", busy, 0);
    send(32'h01097777);
    tick();
    tick();
    m[9] = 16'h7777;
    chk("post_rst_write", reg_out, pack());
    chk("post_rst_strobe", reg_wr_strobe, 16'h0200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/config_reg_bank.md
CONFIG_REG_BANK -- requirements
Module: config_reg_bank

Interface
REQ-001 Parameter NUM_REGS, default 16: number of 16-bit configuration registers (1..256).
REQ-002 Parameter FIFO_DEPTH, default 4: command-word FIFO depth (power of two, at least 2).
REQ-003 Port clk, input, 1: single clock; all logic on rising edge.
REQ-004 Port rst, input, 1: asynchronous active-high reset.
REQ-005 Port config_en, input, 1: one-cycle strobe, config_data valid.
REQ-006 Port config_data, input, 32: command word {opcode[31:24], addr[23:16], data[15:0]}.
REQ-007 Port reg_out, output, NUM_REGS*16: register contents; reg k occupies bits [16k+15:16k].
REQ-008 Port reg_wr_strobe, output, NUM_REGS: one-cycle pulse per register written.
REQ-009 Port busy, output, 1: high when the FIFO is non-empty or the FSM is not IDLE.
REQ-010 Port err, output, 1: one-cycle pulse on overflow, bad opcode or bad address.
REQ-011 Port resp_valid, output, 1: readback byte valid.
REQ-012 Port resp_ready, input, 1: consumer accepts the byte when high together with resp_valid.
REQ-013 Port resp_data, output, 8: readback byte.

Function
REQ-014 Opcodes: 0x01 WRITE, 0x02 READ, 0x03 CLEAR; any other value is invalid.
REQ-015 config_en with FIFO not full pushes config_data; when full, a push in the same cycle as a pop is accepted.
REQ-016 config_en with FIFO full and no pop drops the word; err pulses the next cycle; FIFO contents are unchanged.
REQ-017 FSM states: IDLE, EXEC, RESP_HI, RESP_LO; the FSM pops only in IDLE with the FIFO non-empty, then moves to EXEC.
REQ-018 EXEC lasts one cycle and executes the head word, then returns to IDLE, or goes to RESP_HI for a valid READ.
REQ-019 WRITE with addr < NUM_REGS: reg[addr] takes data on the EXEC edge; reg_wr_strobe[addr] is high for the following cycle.
REQ-020 Latency: from config_en into an empty, idle block to updated reg_out is 3 clock edges; back-to-back writes sustain one write every 2 cycles.
REQ-021 CLEAR: all registers become 0 on the EXEC edge; all reg_wr_strobe bits pulse once; addr and data are ignored.
REQ-022 READ with addr < NUM_REGS: the FSM captures reg[addr], then presents resp_data = high byte in RESP_HI and low byte in RESP_LO.
REQ-023 Each RESP state holds resp_valid high and resp_data stable until resp_ready; the transfer completes on that edge and the FSM advances (RESP_LO goes to IDLE).
REQ-024 Invalid opcode, or addr >= NUM_REGS: err pulses for one cycle after EXEC; no register change, no strobe, no response.
REQ-025 The FIFO keeps accepting pushes while the FSM is in RESP states (backpressure does not block intake).
REQ-026 Simultaneous err sources in one cycle (overflow and bad command) produce a single err pulse.

Reset
REQ-027 On rst assertion, without waiting for clk: all registers are 0, the FIFO is empty, the FSM is IDLE, and reg_wr_strobe, err, busy and resp_valid are 0.
REQ-028 Reset mid-operation discards queued words and any response in flight; no partial write is retained.
REQ-029 On rst release, the first config_en at or after the first rising edge is accepted.

Configuration
REQ-030 Macro CFG_READBACK_EN defined: READ behaves per REQ-022 and REQ-023.
REQ-031 Macro CFG_READBACK_EN undefined: opcode 0x02 is invalid per REQ-024, RESP_HI and RESP_LO are absent, resp_valid is tied to 0, resp_data is tied to 0, and resp_ready is ignored.

Structure
REQ-032 Shared package cfg_pkg SHALL hold the opcode constants, command field bit positions, and the FSM state enumeration.
REQ-033 The FIFO SHALL be a separate sub-module cfg_fifo (synchronous push/pop with full/empty flags), instantiated once.

Verification
REQ-034 The bench SHALL cover: WRITE 0x01_03_ABCD into an idle block -> reg3 = 0xABCD after 3 edges, reg_wr_strobe[3] pulses once, err stays 0.
REQ-035 The bench SHALL cover: 6 back-to-back config_en words at FIFO_DEPTH 4 -> exactly 1 dropped word, err pulses, and the other writes land in order.
REQ-036 The bench SHALL cover: READ 0x02_03_0000 after the REQ-034 write, with resp_ready low 5 cycles -> 0xAB held stable, then 0xCD, then IDLE.
REQ-037 The bench SHALL cover: WRITE 0x01_10_1234 with NUM_REGS 16 -> err pulse, no register change; opcode 0x7F -> err pulse.
REQ-038 The bench SHALL cover: CLEAR 0x03_00_0000 after writes -> all reg_out 0 and all strobes pulse.
REQ-039 The bench SHALL cover: rst asserted during RESP_HI with 2 words queued -> resp_valid 0 immediately, busy 0, and no later writes occur.
